// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer among NREQ byte-stream requesters.
// Round-robin selection with packet locking: an owner keeps the UART until it
// delivers a byte flagged last, or until it idles in READY for LOCK_TIMEOUT cycles.
`timescale 1ns / 1ps

module uart_tx_arbiter #(
   parameter int unsigned NREQ         = 2,
   parameter int unsigned PAYLOAD_BITS = 8,
   parameter int unsigned LOCK_TIMEOUT = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ*PAYLOAD_BITS-1:0] req_data,
   input  logic [NREQ-1:0]              req_last,
   output logic [NREQ-1:0]              req_ready,
   output logic                         uart_tx_en,
   output logic [PAYLOAD_BITS-1:0]      uart_tx_data,
   input  logic                         uart_tx_busy,
   output logic [$clog2(NREQ)-1:0]      grant_id,
   output logic                         active,
   output logic                         drop_event
);

   localparam int unsigned IdW  = $clog2(NREQ);
   localparam int unsigned CntW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
   localparam bit          TimeoutEn  = (LOCK_TIMEOUT != 0);
   localparam logic [CntW-1:0] TimeoutVal = CntW'(LOCK_TIMEOUT);

   typedef enum logic [2:0] {
      StArb,
      StReady,
      StSend,
      StGuard,
      StDrain
   } state_e;

   state_e                  state_q, state_d;
   logic [IdW-1:0]          ptr_q, ptr_d;
   logic [IdW-1:0]          owner_q, owner_d;
   logic                    last_q, last_d;
   logic [PAYLOAD_BITS-1:0] data_q, data_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic                    drop_q, drop_d;

   logic                    pick_found;
   logic [IdW-1:0]          pick_id;
   int unsigned             pick_idx;

   logic                    owner_valid;
   logic                    owner_last;
   logic [PAYLOAD_BITS-1:0] owner_data;
   logic [IdW-1:0]          ptr_next;
   logic                    handshake;

   // Round-robin search: first valid index scanning ptr, ptr+1, ... modulo NREQ.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      pick_idx   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         pick_idx = k + 32'(ptr_q);
         if (pick_idx >= NREQ) begin
            pick_idx = pick_idx - NREQ;
         end
         if (!pick_found && req_valid[IdW'(pick_idx)]) begin
            pick_found = 1'b1;
            pick_id    = IdW'(pick_idx);
         end
      end
   end

   // Select the locked owner's offer; constant part-selects keep the mux simple.
   always_comb begin
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_data  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (owner_q == IdW'(i)) begin
            owner_valid = req_valid[i];
            owner_last  = req_last[i];
            owner_data  = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
         end
      end
   end

   // Ready goes only to the owner, and only while the serializer is idle.
   always_comb begin
      req_ready = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if ((state_q == StReady) && !uart_tx_busy && (owner_q == IdW'(i))) begin
            req_ready[i] = 1'b1;
         end
      end
   end

   assign handshake = (state_q == StReady) && !uart_tx_busy && owner_valid;
   assign ptr_next  = (owner_q == IdW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

   // Next-state logic for the arbitration / issue sequence.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      last_d  = last_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      drop_d  = 1'b0;
      unique case (state_q)
         StArb: begin
            if (pick_found) begin
               owner_d = pick_id;
               cnt_d   = '0;
               state_d = StReady;
            end
         end
         StReady: begin
            // A handshake beats a coincident timeout.
            if (handshake) begin
               data_d  = owner_data;
               last_d  = owner_last;
               cnt_d   = '0;
               state_d = StSend;
            end else begin
               cnt_d = TimeoutEn ? cnt_q + 1'b1 : '0;
               if (TimeoutEn && (cnt_d == TimeoutVal)) begin
                  drop_d  = 1'b1;
                  ptr_d   = ptr_next;
                  cnt_d   = '0;
                  state_d = StArb;
               end
            end
         end
         StSend: begin
            state_d = StGuard;
         end
         StGuard: begin
            // busy rises one cycle after the strobe; don't trust it until now.
            state_d = StDrain;
         end
         StDrain: begin
            if (!uart_tx_busy) begin
               if (last_q) begin
                  ptr_d   = ptr_next;
                  state_d = StArb;
               end else begin
                  state_d = StReady;
               end
            end
         end
         default: begin
            state_d = StArb;
         end
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StArb;
         ptr_q   <= '0;
         owner_q <= '0;
         last_q  <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end
   end

   assign uart_tx_en   = (state_q == StSend);
   assign uart_tx_data = data_q;
   assign grant_id     = owner_q;
   assign active       = (state_q != StArb);
   assign drop_event   = drop_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a busy model of
// uart_tx, and a byte scoreboard filled from the expected arbitration order.
`timescale 1ns / 1ps

module tb_uart_tx_arbiter;

   localparam int unsigned NREQ = 3;
   localparam int unsigned PB   = 8;
   localparam int unsigned TMO  = 16;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   typedef struct {
      logic [NREQ-1:0] valid;
      logic [1:0]      grant;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*PB-1:0] req_data = '0;
   logic [NREQ-1:0]   req_last = '0;
   logic [NREQ-1:0]   req_ready;
   logic              uart_tx_en;
   logic [PB-1:0]     uart_tx_data;
   logic              uart_tx_busy = 1'b0;
   logic [1:0]        grant_id;
   logic              active;
   logic              drop_event;

   beat_t      rq[NREQ][$];
   logic [7:0] exp_q[$];
   int         busy_len = 10;
   int         busy_cnt = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         en_total = 0;
   int         drop_total = 0;

   logic            en_s = 1'b0, en_prev = 1'b0, active_s = 1'b0, drop_s = 1'b0, busy_s = 1'b0;
   logic [NREQ-1:0] ready_s = '0, hs_s = '0;
   logic [7:0]      data_s = '0;
   logic [1:0]      gid_s = '0;

   uart_tx_arbiter #(
      .NREQ         (NREQ),
      .PAYLOAD_BITS (PB),
      .LOCK_TIMEOUT (TMO)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data),
      .uart_tx_busy (uart_tx_busy),
      .grant_id     (grant_id),
      .active       (active),
      .drop_event   (drop_event)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         if (rq[i].size() != 0) begin
            req_valid[i]         = 1'b1;
            req_data[i*PB +: PB] = rq[i][0].d;
            req_last[i]          = rq[i][0].l;
         end else begin
            req_valid[i]         = 1'b0;
            req_data[i*PB +: PB] = '0;
            req_last[i]          = 1'b0;
         end
      end
      uart_tx_busy = (busy_cnt != 0);
   endtask

   task automatic sample();
      logic [7:0] e;
      en_prev  = en_s;
      en_s     = uart_tx_en;
      active_s = active;
      drop_s   = drop_event;
      busy_s   = uart_tx_busy;
      ready_s  = req_ready;
      hs_s     = req_valid & req_ready;
      data_s   = uart_tx_data;
      gid_s    = grant_id;
      if (drop_s) drop_total++;
      chk("ready_onehot0", 32'($onehot0(ready_s)), 32'd1);
      chk("en_while_busy", 32'(en_s & busy_s), 32'd0);
      chk("en_back_to_back", 32'(en_s & en_prev), 32'd0);
      chk("ready_while_busy", 32'(busy_s && (ready_s != '0)), 32'd0);
      chk("ready_in_guard", 32'(en_prev && (ready_s != '0)), 32'd0);
      if (en_s) begin
         en_total++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_byte: got unexpected byte 0x%0h, expected none", data_s);
         end else begin
            e = exp_q.pop_front();
            chk("tx_byte", 32'(data_s), 32'(e));
         end
      end
   endtask

   // One clock: apply consequences of the last cycle after the edge, sample at negedge.
   task automatic step();
      @(posedge clk);
      #1;
      if (rst) begin
         for (int i = 0; i < NREQ; i++) rq[i].delete();
         busy_cnt = 0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (hs_s[i] && (rq[i].size() != 0)) void'(rq[i].pop_front());
         end
         if (en_s) busy_cnt = busy_len;
         else if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
      end
      drive();
      @(negedge clk);
      sample();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic offer(input int i, input logic [7:0] d, input logic l);
      beat_t b;
      b.d = d;
      b.l = l;
      rq[i].push_back(b);
   endtask

   task automatic clear_offers();
      for (int i = 0; i < NREQ; i++) rq[i].delete();
   endtask

   task automatic wait_en(input string name, input int bound, output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!en_s && cyc < bound);
      if (!en_s) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got no uart_tx_en within %0d cycles, expected one", name, bound);
      end
   endtask

   task automatic wait_idle(input string name, input int bound, output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (active_s && cyc < bound);
      if (active_s) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got active=1 after %0d cycles, expected 0", name, bound);
      end
   endtask

   initial begin
      vec_t vt[10];
      int   cyc;
      int   en0;
      int   dr0;

      // ptr evolution starting from 0 after reset; see expected grants.
      vt[0] = '{3'b011, 2'd0};  // ptr 0 -> 1
      vt[1] = '{3'b010, 2'd1};  // ptr 1 -> 2
      vt[2] = '{3'b100, 2'd2};  // ptr 2 -> wraps to 0
      vt[3] = '{3'b011, 2'd0};  // 0 beats 1 after the wrap
      vt[4] = '{3'b111, 2'd1};  // ptr 1 -> 2
      vt[5] = '{3'b111, 2'd2};  // ptr 2 -> 0
      vt[6] = '{3'b110, 2'd1};  // 0 idle, scan reaches 1; ptr -> 2
      vt[7] = '{3'b001, 2'd0};  // scan 2,0; ptr -> 1
      vt[8] = '{3'b101, 2'd2};  // scan 1,2; ptr -> 0
      vt[9] = '{3'b010, 2'd1};  // ptr -> 2

      drive();
      do_reset();
      chk("reset_active", 32'(active_s), 32'd0);
      chk("reset_ready", 32'(ready_s), 32'd0);
      chk("reset_en", 32'(en_s), 32'd0);
      chk("reset_data", 32'(data_s), 32'd0);
      chk("reset_drop", 32'(drop_s), 32'd0);
      chk("reset_grant", 32'(gid_s), 32'd0);

      // Table: single-byte packets, busy never rises (DRAIN must exit at once).
      busy_len = 0;
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (vt[r].valid[i]) offer(i, 8'(r * 16 + i), 1'b1);
         end
         exp_q.push_back(8'(r * 16 + int'(vt[r].grant)));
         step();  // cycle 0: ARB sees valids
         step();  // cycle 1: READY
         chk("vec_ready", 32'(ready_s), 32'(3'b001 << vt[r].grant));
         step();  // cycle 2: SEND
         chk("vec_en_latency", 32'(en_s), 32'd1);
         chk("vec_grant", 32'(gid_s), 32'(vt[r].grant));
         clear_offers();
         wait_idle("vec_idle", 20, cyc);
         chk("vec_sb_empty", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end

      // "OK\n" from requester 0 with a 10-cycle busy serializer.
      busy_len = 10;
      do_reset();
      en0 = en_total;
      offer(0, 8'h4F, 1'b0);
      offer(0, 8'h4B, 1'b0);
      offer(0, 8'h0A, 1'b1);
      exp_q.push_back(8'h4F);
      exp_q.push_back(8'h4B);
      exp_q.push_back(8'h0A);
      for (int b = 0; b < 3; b++) wait_en("ok_byte", 40, cyc);
      wait_idle("ok_idle", 40, cyc);
      chk("ok_release_cycles", 32'(cyc), 32'd12);
      for (int k = 0; k < 5; k++) step();
      chk("ok_en_count", 32'(en_total - en0), 32'd3);
      // ptr must now be 1: with everyone valid, requester 1 wins.
      for (int i = 0; i < NREQ; i++) offer(i, 8'(8'h61 + i), 1'b1);
      exp_q.push_back(8'h62);
      wait_en("ok_ptr_en", 10, cyc);
      chk("ok_ptr_grant", 32'(gid_s), 32'd1);
      clear_offers();
      wait_idle("ok_ptr_idle", 30, cyc);

      // Round-robin with packet locking between requesters 0 and 1.
      do_reset();
      en0 = en_total;
      for (int p = 0; p < 3; p++) begin
         offer(0, 8'hA0, 1'b0);
         offer(0, 8'hA1, 1'b1);
         offer(1, 8'hB0, 1'b0);
         offer(1, 8'hB1, 1'b1);
      end
      for (int p = 0; p < 3; p++) begin
         exp_q.push_back(8'hA0);
         exp_q.push_back(8'hA1);
         exp_q.push_back(8'hB0);
         exp_q.push_back(8'hB1);
      end
      cyc = 0;
      while ((exp_q.size() != 0 || active_s) && cyc < 400) begin
         step();
         cyc++;
      end
      chk("rr_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("rr_idle", 32'(active_s), 32'd0);
      chk("rr_en_count", 32'(en_total - en0), 32'd12);
      exp_q.delete();

      // Lock timeout: requester 1 sends a non-last byte then goes silent.
      do_reset();
      dr0 = drop_total;
      offer(1, 8'h5A, 1'b0);
      exp_q.push_back(8'h5A);
      wait_en("tmo_first_en", 10, cyc);
      chk("tmo_first_grant", 32'(gid_s), 32'd1);
      offer(0, 8'h33, 1'b1);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!drop_s && cyc < 60);
      chk("tmo_drop_latency", 32'(cyc), 32'd28);
      chk("tmo_active_at_drop", 32'(active_s), 32'd0);
      step();
      chk("tmo_drop_one_cycle", 32'(drop_s), 32'd0);
      exp_q.push_back(8'h33);
      wait_en("tmo_next_en", 10, cyc);
      chk("tmo_next_grant", 32'(gid_s), 32'd0);
      wait_idle("tmo_idle", 30, cyc);
      chk("tmo_drop_count", 32'(drop_total - dr0), 32'd1);

      // Reset during DRAIN of the second byte.
      do_reset();
      offer(0, 8'hC0, 1'b0);
      offer(0, 8'hC1, 1'b0);
      offer(0, 8'hC2, 1'b1);
      exp_q.push_back(8'hC0);
      exp_q.push_back(8'hC1);
      wait_en("rst_en0", 40, cyc);
      wait_en("rst_en1", 40, cyc);
      step();  // GUARD
      step();  // DRAIN
      step();  // DRAIN
      rst = 1'b1;
      step();
      chk("midrst_active", 32'(active_s), 32'd0);
      chk("midrst_ready", 32'(ready_s), 32'd0);
      chk("midrst_en", 32'(en_s), 32'd0);
      chk("midrst_data", 32'(data_s), 32'd0);
      chk("midrst_drop", 32'(drop_s), 32'd0);
      chk("midrst_grant", 32'(gid_s), 32'd0);
      rst = 1'b0;
      offer(0, 8'hD0, 1'b1);
      offer(1, 8'hD1, 1'b1);
      exp_q.push_back(8'hD0);
      wait_en("midrst_next_en", 10, cyc);
      chk("midrst_next_grant", 32'(gid_s), 32'd0);
      clear_offers();
      wait_idle("midrst_idle", 30, cyc);
      chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
